// File: rtl/pc_gen_ctrl.sv
// Program-counter generator: issues fetch PCs to the IFU and arbitrates trap > xret > branch redirects.
// Latency: one cycle from redirect/fire to the new pc; pc_valid rises one cycle after reset release.
// Backpressure: pc is held while pc_valid & !pc_ready unless a redirect replaces it; HALT stops issue.
//
// Ports:
//   clk, rst_n                         clock (rising edge) and async active-low reset
//   trap_valid/trap_pc                 trap redirect (highest priority)
//   ret_valid/ret_pc                   xret redirect
//   br_valid/br_pc                     branch/jump redirect (lowest priority)
//   halt_req, resume                   enter / leave HALT (halt_req dominates)
//   pc_ready                           IFU accepts pc this cycle
//   pc_valid, pc                       registered fetch address handshake
//   pc_seq                             pc + STEP, combinational link address
//   redir_pending                      a redirect captured during HALT is waiting
//   misalign_err                       one-cycle pulse: last accepted target had low bits set
//   issue_cnt                          completed handshakes, wrapping
module pc_gen_ctrl #(
  parameter int                     PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC   = 32'h8000_0000,
  parameter int                     STEP       = 4,
  parameter int                     ALIGN_BITS = 2,
  parameter int                     CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 trap_valid,
  input  logic [PC_WIDTH-1:0]  trap_pc,
  input  logic                 ret_valid,
  input  logic [PC_WIDTH-1:0]  ret_pc,
  input  logic                 br_valid,
  input  logic [PC_WIDTH-1:0]  br_pc,
  input  logic                 halt_req,
  input  logic                 resume,
  input  logic                 pc_ready,
  output logic                 pc_valid,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [PC_WIDTH-1:0]  pc_seq,
  output logic                 redir_pending,
  output logic                 misalign_err,
  output logic [CNT_WIDTH-1:0] issue_cnt
);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [PC_WIDTH-1:0] STEP_INC   = PC_WIDTH'(STEP);

  state_t              state;
  logic [PC_WIDTH-1:0] pend_pc;

  logic                redir;
  logic [PC_WIDTH-1:0] sel_pc;
  logic [PC_WIDTH-1:0] tgt;
  logic                sel_mis;
  logic                fire;

  // Fixed-priority redirect select; target is force-aligned, the dropped bits flag an error.
  always_comb begin
    redir = trap_valid | ret_valid | br_valid;
    if (trap_valid)     sel_pc = trap_pc;
    else if (ret_valid) sel_pc = ret_pc;
    else                sel_pc = br_pc;
    tgt     = sel_pc & ~ALIGN_MASK;
    sel_mis = redir & (|(sel_pc & ALIGN_MASK));
  end

  assign fire   = pc_valid & pc_ready;
  assign pc_seq = pc + STEP_INC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      pc_valid      <= 1'b0;
      pend_pc       <= RESET_PC;
      redir_pending <= 1'b0;
      misalign_err  <= 1'b0;
      issue_cnt     <= '0;
    end else begin
      misalign_err <= 1'b0;
      if (fire) issue_cnt <= issue_cnt + 1'b1;

      case (state)
        BOOT: begin
          // Redirects are ignored until the first PC is presented.
          state    <= RUN;
          pc_valid <= 1'b1;
        end

        RUN: begin
          misalign_err <= sel_mis;
          // A redirect replaces even a stalled pc; the stale one is never counted.
          if (redir)     pc <= tgt;
          else if (fire) pc <= pc + STEP_INC;
          if (halt_req) begin
            state    <= HALT;
            pc_valid <= 1'b0;
          end
        end

        HALT: begin
          misalign_err <= sel_mis;
          if (!halt_req && resume) begin
            state         <= RUN;
            pc_valid      <= 1'b1;
            redir_pending <= 1'b0;
            // A redirect arriving in the resume cycle is newer than the held one.
            if (redir)              pc <= tgt;
            else if (redir_pending) pc <= pend_pc;
          end else if (redir) begin
            pend_pc       <= tgt;
            redir_pending <= 1'b1;
          end
        end

        default: begin
          state    <= BOOT;
          pc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen_ctrl.sv
module tb_pc_gen_ctrl;

  localparam int PW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          trap_valid, ret_valid, br_valid;
  logic [PW-1:0] trap_pc, ret_pc, br_pc;
  logic          halt_req, resume, pc_ready;
  logic          pc_valid, redir_pending, misalign_err;
  logic [PW-1:0] pc, pc_seq;
  logic [CW-1:0] issue_cnt;

  int total = 0;
  int bad   = 0;

  pc_gen_ctrl #(
    .PC_WIDTH  (PW),
    .RESET_PC  (32'h8000_0000),
    .STEP      (4),
    .ALIGN_BITS(2),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trap_valid   (trap_valid),
    .trap_pc      (trap_pc),
    .ret_valid    (ret_valid),
    .ret_pc       (ret_pc),
    .br_valid     (br_valid),
    .br_pc        (br_pc),
    .halt_req     (halt_req),
    .resume       (resume),
    .pc_ready     (pc_ready),
    .pc_valid     (pc_valid),
    .pc           (pc),
    .pc_seq       (pc_seq),
    .redir_pending(redir_pending),
    .misalign_err (misalign_err),
    .issue_cnt    (issue_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_redir();
    trap_valid = 1'b0; ret_valid = 1'b0; br_valid = 1'b0;
  endtask

  // Check the common outputs in one call.
  task automatic chk_st(input string tag, input logic v, input logic [PW-1:0] p,
                        input logic [CW-1:0] c, input logic pend, input logic mis);
    chk({tag, ".valid"}, 64'(pc_valid), 64'(v));
    chk({tag, ".pc"},    64'(pc), 64'(p));
    chk({tag, ".cnt"},   64'(issue_cnt), 64'(c));
    chk({tag, ".pend"},  64'(redir_pending), 64'(pend));
    chk({tag, ".mis"},   64'(misalign_err), 64'(mis));
  endtask

  initial begin
    rst_n = 1'b0;
    clr_redir();
    trap_pc = '0; ret_pc = '0; br_pc = '0;
    halt_req = 1'b0; resume = 1'b0; pc_ready = 1'b1;
    #12;
    chk_st("reset", 1'b0, 32'h8000_0000, 4'd0, 1'b0, 1'b0);
    chk("reset.seq", 64'(pc_seq), 64'h8000_0004);
    rst_n = 1'b1;

    // Boot then sequential issue.
    step(); chk_st("boot", 1'b1, 32'h8000_0000, 4'd0, 1'b0, 1'b0);
    step(); chk_st("seq1", 1'b1, 32'h8000_0004, 4'd1, 1'b0, 1'b0);
    step(); chk_st("seq2", 1'b1, 32'h8000_0008, 4'd2, 1'b0, 1'b0);
    step(); chk_st("seq3", 1'b1, 32'h8000_000C, 4'd3, 1'b0, 1'b0);
    step(); chk_st("seq4", 1'b1, 32'h8000_0010, 4'd4, 1'b0, 1'b0);

    // Stall, then redirect while stalled.
    pc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_st("stall", 1'b1, 32'h8000_0010, 4'd4, 1'b0, 1'b0);
    end
    br_valid = 1'b1; br_pc = 32'h8000_0100;
    step(); chk_st("stall_br", 1'b1, 32'h8000_0100, 4'd4, 1'b0, 1'b0);
    clr_redir();

    // Priority and alignment.
    pc_ready = 1'b1;
    trap_valid = 1'b1; trap_pc = 32'h8000_0200;
    ret_valid  = 1'b1; ret_pc  = 32'h8000_0300;
    br_valid   = 1'b1; br_pc   = 32'h8000_0400;
    step(); chk_st("prio_trap", 1'b1, 32'h8000_0200, 4'd5, 1'b0, 1'b0);
    clr_redir();
    br_valid = 1'b1; br_pc = 32'h8000_0402;
    step(); chk_st("misalign", 1'b1, 32'h8000_0400, 4'd6, 1'b0, 1'b1);
    clr_redir();
    step(); chk_st("mis_pulse", 1'b1, 32'h8000_0404, 4'd7, 1'b0, 1'b0);
    ret_valid = 1'b1; br_valid = 1'b1; br_pc = 32'h8000_0400;
    step(); chk_st("prio_ret", 1'b1, 32'h8000_0300, 4'd8, 1'b0, 1'b0);
    clr_redir();

    // Halt with pending redirect, resume picks it up.
    halt_req = 1'b1;
    step(); chk_st("halt", 1'b0, 32'h8000_0304, 4'd9, 1'b0, 1'b0);
    halt_req = 1'b0;
    br_valid = 1'b1; br_pc = 32'h8000_0500;
    step(); chk_st("halt_br", 1'b0, 32'h8000_0304, 4'd9, 1'b1, 1'b0);
    clr_redir();
    step(); chk_st("halt_hold", 1'b0, 32'h8000_0304, 4'd9, 1'b1, 1'b0);
    halt_req = 1'b1; resume = 1'b1;
    step(); chk_st("halt_dom", 1'b0, 32'h8000_0304, 4'd9, 1'b1, 1'b0);
    halt_req = 1'b0;
    step(); chk_st("resume", 1'b1, 32'h8000_0500, 4'd9, 1'b0, 1'b0);
    resume = 1'b0;

    // Redirect in the resume cycle beats the pending target.
    halt_req = 1'b1;
    step(); chk_st("halt2", 1'b0, 32'h8000_0504, 4'd10, 1'b0, 1'b0);
    halt_req = 1'b0;
    br_valid = 1'b1; br_pc = 32'h8000_0600;
    step(); chk_st("halt2_br", 1'b0, 32'h8000_0504, 4'd10, 1'b1, 1'b0);
    br_pc = 32'h8000_0700; resume = 1'b1;
    step(); chk_st("resume_br", 1'b1, 32'h8000_0700, 4'd10, 1'b0, 1'b0);
    clr_redir(); resume = 1'b0;

    // PC and counter wrap.
    br_valid = 1'b1; br_pc = 32'hFFFF_FFFC;
    step(); chk_st("to_top", 1'b1, 32'hFFFF_FFFC, 4'd11, 1'b0, 1'b0);
    chk("top.seq", 64'(pc_seq), 64'h0000_0000);
    clr_redir();
    step(); chk_st("pc_wrap", 1'b1, 32'h0000_0000, 4'd12, 1'b0, 1'b0);
    step(); step(); step();
    chk_st("cnt_max", 1'b1, 32'h0000_000C, 4'd15, 1'b0, 1'b0);
    step(); chk_st("cnt_wrap", 1'b1, 32'h0000_0010, 4'd0, 1'b0, 1'b0);

    // Async reset with a pending redirect.
    halt_req = 1'b1;
    step(); chk_st("halt3", 1'b0, 32'h0000_0014, 4'd1, 1'b0, 1'b0);
    halt_req = 1'b0;
    br_valid = 1'b1; br_pc = 32'h8000_0801;
    step(); chk_st("halt3_br", 1'b0, 32'h0000_0014, 4'd1, 1'b1, 1'b1);
    clr_redir();
    #2 rst_n = 1'b0;
    #1 chk_st("arst", 1'b0, 32'h8000_0000, 4'd0, 1'b0, 1'b0);
    resume = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step(); chk_st("reboot", 1'b1, 32'h8000_0000, 4'd0, 1'b0, 1'b0);
    resume = 1'b0;
    step(); chk_st("post_rst", 1'b1, 32'h8000_0004, 4'd1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
